bdram_be_param: RTL and testbench
=================================

Name: bdram_be_param

Overview:
- Parametrised single-port, byte-write block RAM. Next generation of the fixed 32-bit × 2^17 byte-enable data/instruction RAM in the SRAM-interface SoC.
- Generalised in data width, depth and read-during-write mode.
- Adds an optional output pipeline register, a read-valid strobe, and a hardware clear-on-reset sequencer, so testbenches start from known memory contents.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8. NB = DATA_W/8 byte lanes.
- ADDR_W, 17, word-address width; depth = 2**ADDR_W words.
- RDW_MODE, 0, read-during-write output: 0 = WRITE_FIRST (merged new word), 1 = READ_FIRST (old word), 2 = NO_CHANGE (douta holds).
- OUT_REG, 0, 1 adds a second output register stage; read latency becomes 2.
- CLEAR_ON_RESET, 1, 1 zeroes every word after reset release before accepting access.

Ports:
- clka  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ena  in  1  access enable; reads and writes happen only when ena=1 and init_busy=0.
- wea  in  NB  per-byte write enable; wea[i] covers dina[8i+7:8i]. wea=0 means read.
- addra  in  ADDR_W  word address.
- dina  in  DATA_W  write data.
- douta  out  DATA_W  read data.
- douta_vld  out  1  one-cycle strobe; douta carries the result of an accepted access.
- init_busy  out  1  high while the clear sequencer runs.

Behaviour:
- Reset (resetn=0, async):
  - douta=0 (both stages); douta_vld=0 (both stages).
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - init_busy=1 if CLEAR_ON_RESET=1, else 0.
  - Memory array is not reset asynchronously.
- State CLEAR:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - After writing address 2**ADDR_W-1, moves to IDLE on the next edge and drops init_busy. Total duration 2**ADDR_W cycles.
  - ena/wea/addra/dina are ignored; no douta_vld; douta stays 0.
- State IDLE: normal operation. No other state is entered until the next reset.
- Reset asserted mid-CLEAR: counter returns to 0; clear restarts from address 0 on release.
- Accepted access = ena & ~init_busy.
- Write (accepted, |wea):
  - mem[addra] <= merged word: byte i = wea[i] ? dina byte i : old byte i.
  - Lanes with wea[i]=0 keep their contents.
- Stage-1 douta on accepted access:
  - Read: old mem[addra].
  - Write, RDW_MODE=0: the merged word (not raw dina).
  - Write, RDW_MODE=1: old mem[addra].
  - Write, RDW_MODE=2: stage-1 holds its previous value.
- No accepted access: stage-1 holds its value. Same when ena=1 but init_busy=1.
- douta_vld:
  - Stage-1 valid = 1 for any accepted access, including a NO_CHANGE write. The consumer uses it for handshake timing.
  - OUT_REG=0: douta and douta_vld are stage-1; latency 1.
  - OUT_REG=1: stage-2 registers stage-1 value and valid every cycle; latency 2. Back-to-back accesses produce back-to-back strobes with no bubble.
- Address wrap: addra is exactly ADDR_W bits; no out-of-range condition exists.
- Same-address consecutive cycles: write at cycle N, read at N+1 returns the merged word. No hazard; the array updates at edge N.
- Widths: memory is DATA_W × 2**ADDR_W. Byte lanes are little-endian: lane 0 = bits [7:0].

Test Plan:
Bench instance unless stated: DATA_W=32, ADDR_W=4.

1. Clear sequence: CLEAR_ON_RESET=1. Release resetn.
   - init_busy high for exactly 16 cycles.
   - Reads of all 16 addresses then return 32'h0 with douta_vld 1 cycle later.
   - ena=1 during busy gives no douta_vld.
2. Byte merge: write 32'hAABBCCDD to addr 3 with wea=4'hF, then 32'h11223344 with wea=4'b0101.
   - Read addr 3 returns 32'hAA22CC44.
3. RDW modes: mem[5]=32'h12345678. Write 32'hFFFFFFFF with wea=4'b0011.
   - RDW_MODE=0: douta=32'h1234FFFF.
   - RDW_MODE=1: douta=32'h12345678.
   - RDW_MODE=2: douta equals the previous read value.
   - douta_vld=1 in all three modes.
4. Pipeline: OUT_REG=1. Read addr 0,1,2 on three consecutive cycles.
   - douta_vld high for 3 consecutive cycles, starting 2 cycles after the first request.
   - Data in order: mem[0], mem[1], mem[2].
5. Reset mid-clear: assert resetn=0 at clear cycle 7 for 2 cycles, then release.
   - init_busy lasts a full 16 cycles after release.
   - douta=0 throughout.
6. Idle hold: after a read returning 32'hDEADBEEF, hold ena=0 with random addra/wea for 10 cycles.
   - douta stays 32'hDEADBEEF; douta_vld stays 0; memory is unchanged.

Source files
------------

// File: rtl/bdram_be_param.sv
// Single-port byte-write block RAM with selectable read-during-write behaviour,
// optional output register stage and a zero-fill sequencer after reset.
module bdram_be_param #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 17,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clka,
  input  logic                  resetn,
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
  output logic [DATA_W-1:0]     douta,
  output logic                  douta_vld,
  output logic                  init_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic                busy;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                acc_p0;
  logic                wr_p0;
  logic [DATA_W-1:0]   old_p0;
  logic [DATA_W-1:0]   merged_p0;

  logic [DATA_W-1:0]   dout_p1;
  logic                vld_p1;

  // Byte i of the result comes from new data when its enable is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Clear sequencer: one word per cycle, then IDLE until the next reset
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      busy  <= (CLEAR_ON_RESET != 0);
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + ADDR_W'(1);
      if (cnt == {ADDR_W{1'b1}}) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
    end
  end

  assign init_busy = busy;

  // Stage p0: access decode and array read
  assign acc_p0    = ena & ~busy;
  assign wr_p0     = acc_p0 & (|wea);
  assign old_p0    = mem[addra];
  assign merged_p0 = merge_bytes(old_p0, dina, wea);

  // Array write port, shared between the clear sequencer and byte writes
  always_ff @(posedge clka) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_p0) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  // Stage p1: first output register
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= acc_p0;
      if (acc_p0) begin
        if (!wr_p0) begin
          dout_p1 <= old_p0;
        end else if (RDW_MODE == 0) begin
          dout_p1 <= merged_p0;
        end else if (RDW_MODE == 1) begin
          dout_p1 <= old_p0;
        end
      end
    end
  end

  // Stage p2: optional second output register
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] dout_p2;
      logic              vld_p2;

      always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
          dout_p2 <= '0;
          vld_p2  <= 1'b0;
        end else begin
          dout_p2 <= dout_p1;
          vld_p2  <= vld_p1;
        end
      end

      assign douta     = dout_p2;
      assign douta_vld = vld_p2;
    end else begin : g_no_reg
      assign douta     = dout_p1;
      assign douta_vld = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_bdram_be_param.sv
// Scoreboard bench: three RAM variants share one stimulus stream and are
// checked against a word-array model for data, strobe latency and busy timing.
module tb_bdram_be_param;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  wea = 4'h0;
  logic [3:0]  addra = 4'h0;
  logic [31:0] dina = 32'h0;

  logic [31:0] dout [3];
  logic        vld  [3];
  logic        busy [3];

  always #5 clk = ~clk;

  bdram_be_param #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_wf (
    .clka(clk), .resetn(resetn), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[0]), .douta_vld(vld[0]), .init_busy(busy[0]));
  bdram_be_param #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rf (
    .clka(clk), .resetn(resetn), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[1]), .douta_vld(vld[1]), .init_busy(busy[1]));
  bdram_be_param #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(2), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_nc (
    .clka(clk), .resetn(resetn), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(dout[2]), .douta_vld(vld[2]), .init_busy(busy[2]));

  typedef struct {
    logic [2:0][31:0] d;
    int               due;
  } exp_t;

  exp_t        expq [$];
  int          rd_idx [3];
  logic [31:0] last [3];
  int          extra [3];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] hold_nc;
  int          busy_left;
  int          cyc;
  int          checks;
  int          failures;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic drive(input logic e, input logic [3:0] w, input logic [3:0] a,
                       input logic [31:0] d);
    exp_t        en;
    logic [31:0] old_w, mg;
    @(negedge clk);
    ena = e; wea = w; addra = a; dina = d;
    if (e && resetn && busy_left == 0) begin
      old_w   = mem_m[a];
      mg      = merge(old_w, d, w);
      en.d[0] = (w != 4'h0) ? mg : old_w;
      en.d[1] = old_w;
      en.d[2] = (w != 4'h0) ? hold_nc : old_w;
      hold_nc = en.d[2];
      if (w != 4'h0) mem_m[a] = mg;
      en.due  = cyc + 1;
      expq.push_back(en);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    resetn = 1'b0;
    ena    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_idx[k] = expq.size();
      last[k]   = 32'h0;
    end
    hold_nc   = 32'h0;
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    repeat (n) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'h0, 4'(i), 32'h0);
  endtask

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (resetn && busy_left > 0) busy_left--;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (busy[k] !== (busy_left > 0)) begin
          failures++;
          $display("FAIL busy[%0d] cyc=%0d got=%b want=%b", k, cyc, busy[k], busy_left > 0);
        end
        if (vld[k] === 1'b1) begin
          checks++;
          if (rd_idx[k] < expq.size()) begin
            e = expq[rd_idx[k]];
            rd_idx[k]++;
            if (dout[k] !== e.d[k] || cyc != e.due + extra[k]) begin
              failures++;
              $display("FAIL read[%0d] cyc=%0d got=%h want=%h due_cyc=%0d",
                       k, cyc, dout[k], e.d[k], e.due + extra[k]);
            end
            last[k] = e.d[k];
          end else begin
            failures++;
            $display("FAIL strobe[%0d] cyc=%0d got=unexpected douta_vld want=none", k, cyc);
          end
        end else begin
          checks++;
          if (dout[k] !== last[k]) begin
            failures++;
            $display("FAIL hold[%0d] cyc=%0d got=%h want=%h", k, cyc, dout[k], last[k]);
          end
          if (rd_idx[k] < expq.size() && expq[rd_idx[k]].due + extra[k] <= cyc) begin
            checks++;
            failures++;
            $display("FAIL missed[%0d] cyc=%0d got=no douta_vld want=%h",
                     k, cyc, expq[rd_idx[k]].d[k]);
            rd_idx[k]++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; busy_left = DEPTH; hold_nc = 32'h0;
    extra[0] = 0; extra[1] = 0; extra[2] = 1;
    for (int k = 0; k < 3; k++) begin rd_idx[k] = 0; last[k] = 32'h0; end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;

    // Clear sequence with ena held high while busy, then read everything back
    do_reset(3);
    repeat (16) drive(1'b1, 4'($urandom), 4'($urandom), $urandom);
    read_all();

    // Byte merge
    drive(1'b1, 4'hF, 4'd3, 32'hAABBCCDD);
    drive(1'b1, 4'b0101, 4'd3, 32'h11223344);
    drive(1'b1, 4'h0, 4'd3, 32'h0);

    // Read-during-write, preceded by a read so NO_CHANGE holds a known word
    drive(1'b1, 4'hF, 4'd5, 32'h12345678);
    drive(1'b0, 4'h0, 4'd0, 32'h0);
    drive(1'b1, 4'h0, 4'd5, 32'h0);
    drive(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF);
    drive(1'b1, 4'h0, 4'd5, 32'h0);

    // Back-to-back reads
    drive(1'b1, 4'hF, 4'd1, 32'h01010101);
    drive(1'b1, 4'hF, 4'd2, 32'h02020202);
    drive(1'b1, 4'h0, 4'd0, 32'h0);
    drive(1'b1, 4'h0, 4'd1, 32'h0);
    drive(1'b1, 4'h0, 4'd2, 32'h0);
    drive(1'b0, 4'h0, 4'd0, 32'h0);

    // Idle hold after a read of DEADBEEF
    drive(1'b1, 4'hF, 4'd9, 32'hDEADBEEF);
    drive(1'b1, 4'h0, 4'd9, 32'h0);
    repeat (10) drive(1'b0, 4'($urandom), 4'($urandom), $urandom);
    read_all();

    // Reset mid-clear, then a full clear with ena ignored
    do_reset(2);
    repeat (7) drive(1'b1, 4'($urandom), 4'($urandom), $urandom);
    do_reset(2);
    repeat (16) drive(1'b1, 4'($urandom), 4'($urandom), $urandom);
    read_all();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic       e;
      logic [3:0] w;
      e = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      drive(e, w, 4'($urandom), $urandom);
    end
    read_all();

    repeat (4) drive(1'b0, 4'h0, 4'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_idx[k] != expq.size()) begin
        failures++;
        $display("FAIL drain[%0d] got=%0d consumed want=%0d", k, rd_idx[k], expq.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
